serial_subtractor_fsm: RTL and testbench
========================================

# serial_subtractor_fsm

Bit-serial unsigned subtractor that computes A − B − Bin over WIDTH clock cycles, LSB first. One combinational full-subtractor cell and a registered borrow do the work. It is the subtract-direction companion to the team's full-adder cells. A start/busy/done handshake lets a controller use it as a small-area arithmetic unit where a parallel WIDTH-bit subtractor is not justified.

## Interface
- WIDTH, default 8: operand and result width in bits; legal range 2–32.

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend; sampled with start.
- B  input  WIDTH  subtrahend; sampled with start.
- Bin  input  1  initial borrow; sampled with start.
- busy  output  1  high while an operation is in progress (RUN).
- done  output  1  one-cycle pulse; result valid.
- Diff  output  WIDTH  registered difference; holds until the next completion.
- Bout  output  1  registered final borrow; holds until the next completion.

## Operation
- States are IDLE, RUN and DONE.
- IDLE
  - When start=1 at a clock edge: load A into shift register sa, B into sb, Bin into borrow register br; clear bit counter cnt; go to RUN.
  - When start=0: stay in IDLE.
- RUN: on each edge the cell takes d, bo from (sa[0], sb[0], br).
  - d = sa[0] ^ sb[0] ^ br.
  - bo = (~sa[0] & sb[0]) | (~sa[0] & br) | (sb[0] & br).
  - sa and sb shift right by one.
  - d shifts into the MSB of the internal result register sr; sr shifts right.
  - br ← bo; cnt ← cnt + 1.
  - On the edge where cnt = WIDTH−1: Diff ← final sr value (including this cycle's d), Bout ← bo, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE on the next edge unconditionally.
- Arithmetic
  - Diff = (A − B − Bin) mod 2^WIDTH.
  - Bout = 1 iff A < B + Bin, as unsigned values.
- start while in RUN or DONE is ignored: no restart, no queueing, and A, B, Bin changes have no effect.
- Diff and Bout never show partial results; they change only on the RUN→DONE edge.
- Reset, asserted at any time including mid-RUN: state=IDLE, busy=0, done=0, Diff=0, Bout=0, sa=sb=sr=0, br=0, cnt=0. The operation in flight is discarded.

## Timing
- Reset values: busy 0, done 0, Diff 0, Bout 0.
- busy and done are decoded from the registered state.
  - busy=1 exactly when state=RUN.
  - done=1 exactly when state=DONE.
- Latency, counting start sampled at edge 0:
  - busy is high in the cycles after edges 0 through WIDTH−1.
  - Diff, Bout and done=1 are visible after edge WIDTH.
  - done drops after edge WIDTH+1.
- Throughput: the earliest next start is sampled at edge WIDTH+2, because IDLE is re-entered at edge WIDTH+1. That gives one operation per WIDTH+2 cycles.
- Holding start high continuously gives back-to-back operations at that rate.
- Release of rst is synchronous to clk by the system; the block needs no internal synchronizer.

## Structure
- Package serial_sub_pkg
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2. The unused code 2'd3 returns to IDLE.
  - CNT_W = $clog2(WIDTH) as a function or parameter helper.
- Sub-module full_subtractor: purely combinational.
  - Ports: A, B, Bin in; D, Bout out.
  - Equations as in Operation.
  - Instantiated once in serial_subtractor_fsm.
- Top level holds the FSM, cnt, sa, sb, sr, br and the output registers.

## Test plan
- WIDTH=8, A=100, B=37, Bin=0, start pulsed at edge 0 → busy high for 8 cycles; at edge 8 Diff=63, Bout=0, done=1 for one cycle.
- A=5, B=9, Bin=0 → Diff=252, Bout=1. Then A=0, B=0, Bin=1 → Diff=255, Bout=1. Then A=255, B=255, Bin=0 → Diff=0, Bout=0.
- start re-asserted with A=1, B=1 during RUN of 100−37 → ignored; result still 63/0; only one done pulse.
- rst asserted at cycle 4 of RUN → busy, done, Diff, Bout all 0 immediately, state IDLE. A new start of 200−1 then yields Diff=199, Bout=0.
- start held high for three consecutive operations → done pulses spaced exactly WIDTH+2 cycles apart. Each Diff holds until the next done.
- Random sweep, 1000 vectors at WIDTH=8 and WIDTH=16 → {Bout, Diff} equals the reference model of unsigned A−B−Bin, with borrow as bit WIDTH.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding and counter-width helper for the serial subtractor
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit combinational full subtractor cell (A - B - Bin)
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    assign D    = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~A & Bin) | (B & Bin);

endmodule

// File: rtl/serial_subtractor_fsm.sv
// rtl/serial_subtractor_fsm.sv - bit-serial A - B - Bin, LSB first, with start/busy/done handshake
module serial_subtractor_fsm
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
);

    localparam int              CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-2:0] r_sr;
    logic             r_br;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic             w_d;
    logic             w_bo;
    logic             w_last;
    logic [WIDTH-1:0] w_sr_next;

    full_subtractor u_cell (
        .A    (r_sa[0]),
        .B    (r_sb[0]),
        .Bin  (r_br),
        .D    (w_d),
        .Bout (w_bo)
    );

    // sr only keeps the WIDTH-1 earlier bits; the final bit goes straight into Diff
    assign w_sr_next = {w_d, r_sr};
    assign w_last    = (r_cnt == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = IDLE;
        case (r_state)
            IDLE:    w_state_next = start ? RUN : IDLE;
            RUN:     w_state_next = w_last ? DONE : RUN;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_sr   <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sa  <= A;
                        r_sb  <= B;
                        r_br  <= Bin;
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
                    r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
                    r_sr  <= w_sr_next[WIDTH-1:1];
                    r_br  <= w_bo;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_diff <= w_sr_next;
                        r_bout <= w_bo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign Diff = r_diff;
    assign Bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor_fsm.sv
// tb/tb_serial_subtractor_fsm.sv - directed and random checks of serial_subtractor_fsm at WIDTH 8 and 16
module tb_serial_subtractor_fsm;

    logic        clk;
    logic        rst;

    logic        start8, Bin8, busy8, done8, Bout8;
    logic [7:0]  A8, B8, Diff8;
    logic        start16, Bin16, busy16, done16, Bout16;
    logic [15:0] A16, B16, Diff16;

    int n_assert = 0;
    int n_fail   = 0;
    int n_done8  = 0;
    int cyc      = 0;

    logic [8:0]  q8[$];
    logic [16:0] q16[$];

    serial_subtractor_fsm #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(A8), .B(B8), .Bin(Bin8),
        .busy(busy8), .done(done8), .Diff(Diff8), .Bout(Bout8)
    );

    serial_subtractor_fsm #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .A(A16), .B(B16), .Bin(Bin16),
        .busy(busy16), .done(done16), .Diff(Diff16), .Bout(Bout16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        return {1'b0, a} - {1'b0, b} - {8'd0, bin};
    endfunction

    function automatic logic [16:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic bin);
        return {1'b0, a} - {1'b0, b} - {16'd0, bin};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            n_done8++;
            check("q8_nonempty_on_done", 32'(q8.size() != 0), 32'd1);
            if (q8.size() != 0) check("result8", {Bout8, Diff8}, q8.pop_front());
        end
        if (done16 === 1'b1) begin
            check("q16_nonempty_on_done", 32'(q16.size() != 0), 32'd1);
            if (q16.size() != 0) check("result16", {Bout16, Diff16}, q16.pop_front());
        end
    end

    task automatic wait_done8(input int lim, input logic chk_hold, input logic [7:0] held);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
            if (chk_hold && done8 !== 1'b1) check("diff8_hold", Diff8, held);
        end while (done8 !== 1'b1 && k < lim);
        if (done8 !== 1'b1) check("done8_timeout", done8, 1'b1);
    endtask

    task automatic wait_done16(input int lim);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (done16 !== 1'b1 && k < lim);
        if (done16 !== 1'b1) check("done16_timeout", done16, 1'b1);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        @(posedge clk); #1;
        A8 = a; B8 = b; Bin8 = bin; start8 = 1'b1;
        q8.push_back(ref8(a, b, bin));
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done8(20, 1'b0, 8'd0);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bin);
        @(posedge clk); #1;
        A16 = a; B16 = b; Bin16 = bin; start16 = 1'b1;
        q16.push_back(ref16(a, b, bin));
        @(posedge clk); #1;
        start16 = 1'b0;
        wait_done16(30);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0, t1, t2, t3;
        rst = 1'b1;
        start8 = 0;  A8 = '0;  B8 = '0;  Bin8 = 0;
        start16 = 0; A16 = '0; B16 = '0; Bin16 = 0;
        #2;
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_diff8", Diff8, 0);
        check("rst_bout8", Bout8, 0);
        check("rst_busy16", busy16, 0);
        check("rst_diff16", {Bout16, Diff16}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 100 - 37: busy for exactly 8 cycles, Diff unchanged until completion
        @(posedge clk); #1;
        A8 = 8'd100; B8 = 8'd37; Bin8 = 0; start8 = 1'b1;
        q8.push_back(ref8(8'd100, 8'd37, 1'b0));
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("run_busy8", busy8, 1);
            check("run_done8", done8, 0);
            check("run_no_partial8", {Bout8, Diff8}, 0);
        end
        @(negedge clk);
        check("edge8_busy8", busy8, 0);
        check("edge8_done8", done8, 1);
        check("edge8_diff8", Diff8, 8'd63);
        @(negedge clk);
        check("edge9_done8", done8, 0);
        check("edge9_diff_held8", Diff8, 8'd63);

        op8(8'd5, 8'd9, 1'b0);
        op8(8'd0, 8'd0, 1'b1);
        op8(8'd255, 8'd255, 1'b0);

        // start re-asserted with new operands during RUN must be ignored
        @(posedge clk); #1;
        A8 = 8'd100; B8 = 8'd37; Bin8 = 0; start8 = 1'b1;
        q8.push_back(ref8(8'd100, 8'd37, 1'b0));
        @(posedge clk); #1;
        start8 = 1'b0;
        d0 = n_done8;
        @(posedge clk); #1;
        A8 = 8'd1; B8 = 8'd1; Bin8 = 1'b1; start8 = 1'b1;
        wait_done8(20, 1'b0, 8'd0);
        start8 = 1'b0;
        check("ignored_restart_diff8", {Bout8, Diff8}, {1'b0, 8'd63});
        repeat (12) @(negedge clk);
        check("ignored_restart_one_done", n_done8 - d0, 1);
        check("ignored_restart_idle", busy8, 0);

        // asynchronous reset mid-RUN discards the operation
        op8(8'd5, 8'd9, 1'b0);
        @(posedge clk); #1;
        A8 = 8'd100; B8 = 8'd37; Bin8 = 0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrun_rst_busy8", busy8, 0);
        check("midrun_rst_done8", done8, 0);
        check("midrun_rst_diff8", Diff8, 0);
        check("midrun_rst_bout8", Bout8, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle8", busy8, 0);
        op8(8'd200, 8'd1, 1'b0);
        check("post_rst_diff8", {Bout8, Diff8}, {1'b0, 8'd199});

        // start held high: back-to-back operations every WIDTH+2 cycles
        @(posedge clk); #1;
        A8 = 8'd10; B8 = 8'd3; Bin8 = 0; start8 = 1'b1;
        q8.push_back(ref8(8'd10, 8'd3, 1'b0));
        wait_done8(20, 1'b0, 8'd0);
        t1 = cyc;
        A8 = 8'd20; B8 = 8'd5; Bin8 = 1'b1;
        q8.push_back(ref8(8'd20, 8'd5, 1'b1));
        wait_done8(20, 1'b1, 8'd7);
        t2 = cyc;
        A8 = 8'd200; B8 = 8'd100; Bin8 = 0;
        q8.push_back(ref8(8'd200, 8'd100, 1'b0));
        wait_done8(20, 1'b1, 8'd14);
        t3 = cyc;
        start8 = 1'b0;
        check("b2b_spacing_1", t2 - t1, 10);
        check("b2b_spacing_2", t3 - t2, 10);

        for (int i = 0; i < 1000; i++) op8(8'($urandom), 8'($urandom), 1'($urandom));
        op16(16'd0, 16'd1, 1'b0);
        op16(16'hFFFF, 16'h0000, 1'b1);
        for (int i = 0; i < 1000; i++) op16(16'($urandom), 16'($urandom), 1'($urandom));

        repeat (3) @(negedge clk);
        check("q8_drained", q8.size(), 0);
        check("q16_drained", q16.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
